// File: rtl/riscv_alu_operand_stage_if.sv
// Decode-to-ALU operand stage bus: decode inputs, forwarding network, and the
// registered operand outputs with their valid/ready handshake.
interface riscv_alu_operand_stage_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned CNT_W   = 16
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [2:0]               src_a;
  logic [2:0]               src_b;
  logic [4:0]               rs1_addr;
  logic [4:0]               rs2_addr;
  logic [XLEN-1:0]          rs1_data;
  logic [XLEN-1:0]          rs2_data;
  logic [XLEN-1:0]          imm;
  logic [$clog2(XLEN)-1:0]  shamt;
  logic [XLEN-1:0]          pc;
  logic                     is_compressed;
  logic [XLEN-1:0]          csr_data;
  logic [NUM_FWD-1:0]       fwd_valid;
  logic [NUM_FWD*5-1:0]     fwd_rd;
  logic [NUM_FWD*XLEN-1:0]  fwd_data;
  logic [NUM_FWD-1:0]       fwd_data_rdy;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          op_a;
  logic [XLEN-1:0]          op_b;
  logic                     hazard_stall;
  logic [CNT_W-1:0]         stall_count;

  modport master (
    output flush, in_valid, src_a, src_b, rs1_addr, rs2_addr, rs1_data, rs2_data,
           imm, shamt, pc, is_compressed, csr_data, fwd_valid, fwd_rd, fwd_data,
           fwd_data_rdy, out_ready,
    input  in_ready, out_valid, op_a, op_b, hazard_stall, stall_count
  );

  modport slave (
    input  flush, in_valid, src_a, src_b, rs1_addr, rs2_addr, rs1_data, rs2_data,
           imm, shamt, pc, is_compressed, csr_data, fwd_valid, fwd_rd, fwd_data,
           fwd_data_rdy, out_ready,
    output in_ready, out_valid, op_a, op_b, hazard_stall, stall_count
  );
endinterface

// File: rtl/riscv_alu_operand_stage.sv
// Registered ALU operand-select stage with register forwarding, pending-forward
// hazard stalls, compressed-aware next-PC and a saturating stall counter.
module riscv_alu_operand_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned CNT_W   = 16
) (
  input logic                     clk,
  input logic                     reset_n,
  riscv_alu_operand_stage_if.slave bus
);
  localparam int unsigned SHW = $clog2(XLEN);

  typedef enum logic [2:0] {
    ALU_SRC_NULL    = 3'd0,
    ALU_SRC_REG     = 3'd1,
    ALU_SRC_IMM     = 3'd2,
    ALU_SRC_SHAMT   = 3'd3,
    ALU_SRC_PC      = 3'd4,
    ALU_SRC_PC_NEXT = 3'd5,
    ALU_SRC_CSR     = 3'd6
  } alu_src_e;

  typedef struct packed {
    logic            hazard;
    logic [XLEN-1:0] data;
  } res_t;

  function automatic res_t resolve(
    input logic [4:0]              addr,
    input logic [XLEN-1:0]         rf,
    input logic [NUM_FWD-1:0]      vld,
    input logic [NUM_FWD*5-1:0]    rd,
    input logic [NUM_FWD*XLEN-1:0] dat,
    input logic [NUM_FWD-1:0]      rdy
  );
    res_t r;
    r.hazard = 1'b0;
    r.data   = rf;
    // Walk oldest to youngest so the youngest match overrides everything older,
    // including an older ready producer behind a younger pending one.
    for (int unsigned k = 0; k < NUM_FWD; k++) begin
      int unsigned i;
      i = NUM_FWD - 1 - k;
      if (vld[i] && (rd[5*i +: 5] == addr)) begin
        r.hazard = !rdy[i];
        r.data   = dat[XLEN*i +: XLEN];
      end
    end
    if (addr == 5'd0) begin
      r.hazard = 1'b0;
      r.data   = '0;
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] select_src(
    input logic [2:0]      code,
    input logic [XLEN-1:0] reg_val,
    input logic [XLEN-1:0] imm,
    input logic [XLEN-1:0] shamt_ext,
    input logic [XLEN-1:0] pc,
    input logic [XLEN-1:0] pc_next,
    input logic [XLEN-1:0] csr
  );
    logic [XLEN-1:0] v;
    case (alu_src_e'(code))
      ALU_SRC_REG:     v = reg_val;
      ALU_SRC_IMM:     v = imm;
      ALU_SRC_SHAMT:   v = shamt_ext;
      ALU_SRC_PC:      v = pc;
      ALU_SRC_PC_NEXT: v = pc_next;
      ALU_SRC_CSR:     v = csr;
      default:         v = '0;
    endcase
    return v;
  endfunction

  res_t            res_a;
  res_t            res_b;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] shamt_ext;
  logic            haz_a;
  logic            haz_b;
  logic            hazard_stall;
  logic            in_ready;
  logic            capture;

  logic            out_valid_d, out_valid_q;
  logic [XLEN-1:0] op_a_d, op_a_q;
  logic [XLEN-1:0] op_b_d, op_b_q;
  logic [CNT_W-1:0] stall_count_d, stall_count_q;

  always_comb begin
    res_a = resolve(bus.rs1_addr, bus.rs1_data, bus.fwd_valid, bus.fwd_rd,
                    bus.fwd_data, bus.fwd_data_rdy);
    res_b = resolve(bus.rs2_addr, bus.rs2_data, bus.fwd_valid, bus.fwd_rd,
                    bus.fwd_data, bus.fwd_data_rdy);

    pc_next   = bus.pc + (bus.is_compressed ? XLEN'(2) : XLEN'(4));
    shamt_ext = XLEN'(bus.shamt);

    haz_a = bus.in_valid && (bus.src_a == ALU_SRC_REG) && res_a.hazard;
    haz_b = bus.in_valid && (bus.src_b == ALU_SRC_REG) && res_b.hazard;
    hazard_stall = haz_a || haz_b;

    in_ready = (!out_valid_q || bus.out_ready) && !hazard_stall;
    capture  = bus.in_valid && in_ready && !bus.flush;

    out_valid_d = out_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
      op_a_d = select_src(bus.src_a, res_a.data, bus.imm, shamt_ext, bus.pc,
                          pc_next, bus.csr_data);
      op_b_d = select_src(bus.src_b, res_b.data, bus.imm, shamt_ext, bus.pc,
                          pc_next, bus.csr_data);
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    stall_count_d = stall_count_q;
    if (hazard_stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q   <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      stall_count_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.hazard_stall = hazard_stall;
  assign bus.out_valid    = out_valid_q;
  assign bus.op_a         = op_a_q;
  assign bus.op_b         = op_b_q;
  assign bus.stall_count  = stall_count_q;

endmodule

// File: tb/tb_riscv_alu_operand_stage.sv
// Directed bench for riscv_alu_operand_stage: driver queues expected operands,
// a negedge monitor pops them on every ALU handshake.
module tb_riscv_alu_operand_stage;
  localparam logic [2:0] S_NULL = 3'd0, S_REG = 3'd1, S_IMM = 3'd2, S_SHAMT = 3'd3,
                         S_PC = 3'd4, S_PCN = 3'd5, S_CSR = 3'd6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  riscv_alu_operand_stage_if #(.XLEN(32), .NUM_FWD(3), .CNT_W(16)) b ();
  riscv_alu_operand_stage_if #(.XLEN(32), .NUM_FWD(3), .CNT_W(2))  s ();

  riscv_alu_operand_stage #(.XLEN(32), .NUM_FWD(3), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(b));
  riscv_alu_operand_stage #(.XLEN(32), .NUM_FWD(3), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .bus(s));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] bb);
    exp_t e;
    e.a = a;
    e.b = bb;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake is out_valid && out_ready seen mid-cycle.
  always @(negedge clk) begin
    if (reset_n && b.out_valid && b.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'(b.op_a), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("op_a", 64'(b.op_a), 64'(e.a));
        chk("op_b", 64'(b.op_b), 64'(e.b));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

  initial begin
    b.flush = 0; b.in_valid = 0; b.src_a = S_NULL; b.src_b = S_NULL;
    b.rs1_addr = 0; b.rs2_addr = 0; b.rs1_data = 0; b.rs2_data = 0;
    b.imm = 0; b.shamt = 0; b.pc = 0; b.is_compressed = 0; b.csr_data = 0;
    b.fwd_valid = 0; b.fwd_rd = 0; b.fwd_data = 0; b.fwd_data_rdy = 0;
    b.out_ready = 1;
    // Saturation instance: a permanent pending forward on x1.
    s.flush = 0; s.in_valid = 1; s.src_a = S_REG; s.src_b = S_NULL;
    s.rs1_addr = 5'd1; s.rs2_addr = 0; s.rs1_data = 0; s.rs2_data = 0;
    s.imm = 0; s.shamt = 0; s.pc = 0; s.is_compressed = 0; s.csr_data = 0;
    s.fwd_valid = 3'b001; s.fwd_rd = {5'd0, 5'd0, 5'd1}; s.fwd_data = 0;
    s.fwd_data_rdy = 0; s.out_ready = 1;

    step(); step();
    chk("rst_out_valid", 64'(b.out_valid), 0);
    chk("rst_op_a", 64'(b.op_a), 0);
    chk("rst_op_b", 64'(b.op_b), 0);
    chk("rst_stall_count", 64'(b.stall_count), 0);
    reset_n = 1;
    step();

    // PC / IMM
    b.in_valid = 1; b.src_a = S_PC; b.src_b = S_IMM; b.pc = 32'h100; b.imm = 32'h10;
    #1 chk("in_ready_t1", 64'(b.in_ready), 1);
    push(32'h100, 32'h10);
    step();
    chk("latency_out_valid", 64'(b.out_valid), 1);

    // PC_NEXT wrap, compressed and not
    b.src_a = S_PCN; b.src_b = S_NULL; b.pc = 32'hFFFF_FFFE; b.is_compressed = 1;
    push(32'h0, 32'h0);
    step();
    b.is_compressed = 0;
    push(32'h2, 32'h0);
    step();
    b.src_a = S_SHAMT; b.shamt = 5'd31; b.src_b = S_CSR; b.csr_data = 32'hC5C5;
    push(32'h1F, 32'hC5C5);
    step();
    b.src_a = 3'b111; b.src_b = 3'b111;
    push(32'h0, 32'h0);
    step();

    // Two ready matches on x5: youngest (producer 0) wins
    b.src_a = S_REG; b.rs1_addr = 5'd5; b.rs1_data = 32'hDEAD;
    b.src_b = S_REG; b.rs2_addr = 5'd9; b.rs2_data = 32'h99;
    b.fwd_valid = 3'b101; b.fwd_rd = {5'd5, 5'd0, 5'd5};
    b.fwd_data = {32'hBBBB, 32'h0, 32'hAAAA}; b.fwd_data_rdy = 3'b111;
    push(32'hAAAA, 32'h99);
    step();

    // x0 never forwarded, never stalls
    b.rs1_addr = 5'd0; b.rs1_data = 32'h5555;
    b.fwd_valid = 3'b001; b.fwd_rd = {5'd0, 5'd0, 5'd0}; b.fwd_data_rdy = 3'b000;
    #1 chk("x0_hazard", 64'(b.hazard_stall), 0);
    chk("x0_in_ready", 64'(b.in_ready), 1);
    push(32'h0, 32'h99);
    step();

    // Younger pending producer blocks older ready one on x7
    b.src_a = S_IMM; b.imm = 32'h1; b.src_b = S_REG; b.rs2_addr = 5'd7;
    b.fwd_valid = 3'b011; b.fwd_rd = {5'd0, 5'd7, 5'd7};
    b.fwd_data = {32'h0, 32'h5678, 32'h1234}; b.fwd_data_rdy = 3'b010;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_hazard", 64'(b.hazard_stall), 1);
      chk("stall_in_ready", 64'(b.in_ready), 0);
      step();
    end
    chk("stall_count_3", 64'(b.stall_count), 3);
    b.fwd_data_rdy = 3'b011;
    #1 chk("release_hazard", 64'(b.hazard_stall), 0);
    chk("release_in_ready", 64'(b.in_ready), 1);
    push(32'h1, 32'h1234);
    step();
    chk("stall_count_hold", 64'(b.stall_count), 3);
    chk("release_out_valid", 64'(b.out_valid), 1);

    // Backpressure hold
    b.fwd_valid = 0; b.fwd_data_rdy = 0; b.out_ready = 0;
    b.src_a = S_IMM; b.imm = 32'h11; b.src_b = S_PC; b.pc = 32'h200;
    for (int i = 0; i < 4; i++) begin
      #1 chk("hold_in_ready", 64'(b.in_ready), 0);
      step();
      chk("hold_op_a", 64'(b.op_a), 32'h1);
      chk("hold_op_b", 64'(b.op_b), 32'h1234);
      chk("hold_out_valid", 64'(b.out_valid), 1);
    end
    b.out_ready = 1;
    #1 chk("unhold_in_ready", 64'(b.in_ready), 1);
    push(32'h11, 32'h200);
    step();
    b.imm = 32'h22;
    push(32'h22, 32'h200);
    step();
    chk("b2b_out_valid", 64'(b.out_valid), 1);
    b.imm = 32'h33;
    push(32'h33, 32'h200);
    step();
    chk("b2b_out_valid2", 64'(b.out_valid), 1);
    b.in_valid = 0;
    step(); step();
    chk("drained_out_valid", 64'(b.out_valid), 0);

    // Flush dominates capture
    b.in_valid = 1; b.src_a = S_IMM; b.imm = 32'h77; b.flush = 1;
    #1 chk("flush_in_ready", 64'(b.in_ready), 1);
    step();
    b.flush = 0; b.in_valid = 0;
    chk("flush_out_valid", 64'(b.out_valid), 0);
    step();

    // Reset during hold + stall drops everything
    b.out_ready = 0; b.in_valid = 1; b.src_a = S_IMM; b.imm = 32'h42;
    b.src_b = S_CSR; b.csr_data = 32'h43;
    push(32'h42, 32'h43);
    step();
    b.src_a = S_REG; b.rs1_addr = 5'd3; b.src_b = S_NULL;
    b.fwd_valid = 3'b001; b.fwd_rd = {5'd0, 5'd0, 5'd3}; b.fwd_data_rdy = 3'b000;
    #1 chk("stall2_hazard", 64'(b.hazard_stall), 1);
    step(); step();
    chk("stall_count_5", 64'(b.stall_count), 5);
    #2 reset_n = 0; b.in_valid = 0;
    exp_q.delete();
    #1;
    chk("arst_out_valid", 64'(b.out_valid), 0);
    chk("arst_op_a", 64'(b.op_a), 0);
    chk("arst_op_b", 64'(b.op_b), 0);
    chk("arst_stall_count", 64'(b.stall_count), 0);
    step(); step();
    b.out_ready = 1; b.fwd_valid = 0;
    reset_n = 1;
    step(); step();
    chk("post_rst_out_valid", 64'(b.out_valid), 0);

    step(); step(); step(); step();
    chk("sat_stall_count", 64'(s.stall_count), 3);
    chk("sat_hazard", 64'(s.hazard_stall), 1);
    chk("queue_empty", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
